// File: rtl/regfile_2r1w.sv
// regfile_2r1w: DEPTH x DATA_W register file with one synchronous write port,
// two registered read ports (write-first bypass) and a background clear engine
// that zeroes one entry per cycle while BUSY is high.
// Optional build macro REGFILE_ZERO_REG_EN: entry 0 reads as zero and ignores writes.
module regfile_2r1w #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [DATA_W-1:0] WDATA,
  input  logic              RE_A,
  input  logic [ADDR_W-1:0] RADDR_A,
  output logic [DATA_W-1:0] RDATA_A,
  output logic              RVALID_A,
  input  logic              RE_B,
  input  logic [ADDR_W-1:0] RADDR_B,
  output logic [DATA_W-1:0] RDATA_B,
  output logic              RVALID_B,
  input  logic              CLR,
  output logic              BUSY,
  output logic              WDROP
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              busy_q, busy_d;
  logic              wdrop_q, wdrop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic              wr_ok;
  logic              scrub;

  // Next-state: clear sequencing, write acceptance and read-data selection.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_d     = busy_q;
    wdrop_d    = wdrop_q;
    mem_d      = mem_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = RE_A;
    rvalid_b_d = RE_B;
    scrub      = (state_q == CLEAR);

    // A write lands only in IDLE and never alongside a clear start.
`ifdef REGFILE_ZERO_REG_EN
    wr_ok = (state_q == IDLE) && WE && !CLR && (WADDR != '0);
`else
    wr_ok = (state_q == IDLE) && WE && !CLR;
`endif

    case (state_q)
      IDLE: begin
        if (CLR) begin
          state_d = CLEAR;
          ptr_d   = '0;
          busy_d  = 1'b1;
          // A clear start resets the sticky flag, except that a write
          // colliding with the start is itself a dropped write.
          wdrop_d = WE;
        end
      end
      CLEAR: begin
        mem_d[ptr_q] = '0;
        ptr_d        = ptr_q + ADDR_W'(1);
        if (WE) wdrop_d = 1'b1;
        if (ptr_q == '1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_ok) mem_d[WADDR] = WDATA;
`ifdef REGFILE_ZERO_REG_EN
    mem_d[0] = '0;
`endif

    // Priority: accepted write bypass, then scrub bypass, then array.
    if (RE_A) begin
      if (wr_ok && (RADDR_A == WADDR))      rdata_a_d = WDATA;
      else if (scrub && (RADDR_A == ptr_q)) rdata_a_d = '0;
      else                                  rdata_a_d = mem_q[RADDR_A];
    end
    if (RE_B) begin
      if (wr_ok && (RADDR_B == WADDR))      rdata_b_d = WDATA;
      else if (scrub && (RADDR_B == ptr_q)) rdata_b_d = '0;
      else                                  rdata_b_d = mem_q[RADDR_B];
    end
  end

  // State, array and output registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      wdrop_q    <= 1'b0;
      mem_q      <= '{default: '0};
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      wdrop_q    <= wdrop_d;
      mem_q      <= mem_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  assign RDATA_A  = rdata_a_q;
  assign RVALID_A = rvalid_a_q;
  assign RDATA_B  = rdata_b_q;
  assign RVALID_B = rvalid_b_q;
  assign BUSY     = busy_q;
  assign WDROP    = wdrop_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Directed bench for regfile_2r1w: table of single-cycle vectors followed by
// hand-written clear-engine and reset-during-clear sequences.
module tb_regfile_2r1w;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        CLK, RST_N, WE, RE_A, RE_B, CLR;
  logic [4:0]  WADDR, RADDR_A, RADDR_B;
  logic [31:0] WDATA, RDATA_A, RDATA_B;
  logic        RVALID_A, RVALID_B, BUSY, WDROP;

  int n_cmp;
  int n_fail;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
    .RE_A(RE_A), .RADDR_A(RADDR_A), .RDATA_A(RDATA_A), .RVALID_A(RVALID_A),
    .RE_B(RE_B), .RADDR_B(RADDR_B), .RDATA_B(RDATA_B), .RVALID_B(RVALID_B),
    .CLR(CLR), .BUSY(BUSY), .WDROP(WDROP)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re_a;
    logic [4:0]  ra;
    logic        re_b;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic        exp_va;
    logic [31:0] exp_b;
    logic        exp_vb;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic quiet();
    WE = 1'b0; RE_A = 1'b0; RE_B = 1'b0; CLR = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    quiet();
    WE = 1'b1; WADDR = a; WDATA = d;
    step();
    quiet();
  endtask

  task automatic rd_a(input logic [4:0] a, input logic [31:0] exp, input string nm);
    quiet();
    RE_A = 1'b1; RADDR_A = a;
    step();
    quiet();
    chk(nm, RDATA_A, exp);
  endtask

  initial begin
    logic [31:0] z0, zb;
    int n;
    n_cmp = 0; n_fail = 0;
    quiet();
    WADDR = '0; WDATA = '0; RADDR_A = '0; RADDR_B = '0;
    RST_N = 1'b0;
    z0 = ZR ? 32'h0 : 32'hFFFF_FFFF;
    zb = ZR ? 32'h0 : 32'hAAAA_5555;

    //           we wa  wdata          reA ra  reB rb  expA           vA   expB           vB
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 1'b0, 5'd0,  1'b0, 5'd0,  32'h0,          1'b0, 32'h0,          1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b0, 5'd0,  32'hDEAD_BEEF,  1'b1, 32'h0,          1'b0};
    vecs[2] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  1'b0, 5'd0,  32'hDEAD_BEEF,  1'b0, 32'h0,          1'b0};
    vecs[3] = '{1'b1, 5'd7,  32'h1234_5678, 1'b1, 5'd7,  1'b1, 5'd7,  32'h1234_5678,  1'b1, 32'h1234_5678,  1'b1};
    vecs[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd5,  1'b1, 5'd7,  32'hDEAD_BEEF,  1'b1, 32'h1234_5678,  1'b1};
    vecs[5] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  1'b0, 5'd0,  32'hDEAD_BEEF,  1'b0, 32'h1234_5678,  1'b0};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  1'b1, 5'd0,  z0,             1'b1, z0,             1'b1};
    vecs[7] = '{1'b1, 5'd0,  32'hAAAA_5555, 1'b1, 5'd0,  1'b0, 5'd0,  zb,             1'b1, z0,             1'b0};
    vecs[8] = '{1'b1, 5'd31, 32'h0BAD_F00D, 1'b1, 5'd31, 1'b1, 5'd31, 32'h0BAD_F00D,  1'b1, 32'h0BAD_F00D,  1'b1};
    vecs[9] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  1'b1, 5'd5,  32'h1234_5678,  1'b1, 32'hDEAD_BEEF,  1'b1};

    #22 RST_N = 1'b1;
    chk("rst_rdata_a", RDATA_A, 32'h0);
    chk("rst_rvalid_a", {31'b0, RVALID_A}, 32'h0);
    chk("rst_busy", {31'b0, BUSY}, 32'h0);
    chk("rst_wdrop", {31'b0, WDROP}, 32'h0);
    step();

    for (int i = 0; i < 10; i++) begin
      WE = vecs[i].we; WADDR = vecs[i].waddr; WDATA = vecs[i].wdata;
      RE_A = vecs[i].re_a; RADDR_A = vecs[i].ra;
      RE_B = vecs[i].re_b; RADDR_B = vecs[i].rb;
      step();
      chk($sformatf("v%0d_rdata_a", i), RDATA_A, vecs[i].exp_a);
      chk($sformatf("v%0d_rvalid_a", i), {31'b0, RVALID_A}, {31'b0, vecs[i].exp_va});
      chk($sformatf("v%0d_rdata_b", i), RDATA_B, vecs[i].exp_b);
      chk($sformatf("v%0d_rvalid_b", i), {31'b0, RVALID_B}, {31'b0, vecs[i].exp_vb});
      chk($sformatf("v%0d_wdrop", i), {31'b0, WDROP}, 32'h0);
    end
    quiet();

    // Fill with value = address, then run a full clear.
    for (int a = 0; a < 32; a++) wr(5'(a), 32'(a));
    CLR = 1'b1;
    step();
    quiet();
    chk("clr_busy_start", {31'b0, BUSY}, 32'h1);
    chk("clr_wdrop_start", {31'b0, WDROP}, 32'h0);
    for (int k = 1; k <= 32; k++) begin
      quiet();
      case (k)
        3:  begin RE_B = 1'b1; RADDR_B = 5'd3; end
        4:  begin RE_A = 1'b1; RADDR_A = 5'd3; end
        5:  begin RE_A = 1'b1; RADDR_A = 5'd2; end
        6:  begin WE = 1'b1; WADDR = 5'd1; WDATA = 32'h77; end
        8:  CLR = 1'b1;
        10: begin RE_A = 1'b1; RADDR_A = 5'd31; end
        default: ;
      endcase
      step();
      chk($sformatf("clr_busy_k%0d", k), {31'b0, BUSY}, (k < 32) ? 32'h1 : 32'h0);
      if (k == 3)  chk("clr_rd3_ptr2", RDATA_B, 32'h3);
      if (k == 4)  chk("clr_rd3_ptr3", RDATA_A, 32'h0);
      if (k == 5)  chk("clr_rd2_done", RDATA_A, 32'h0);
      if (k == 6)  chk("clr_wdrop_set", {31'b0, WDROP}, 32'h1);
      if (k == 10) chk("clr_rd31_k10", RDATA_A, 32'h1F);
    end
    quiet();
    rd_a(5'd31, 32'h0, "post_clr_rd31");
    rd_a(5'd1, 32'h0, "post_clr_rd1_dropped");
    chk("post_clr_wdrop_sticky", {31'b0, WDROP}, 32'h1);

    // A fresh clear start resets WDROP and runs exactly 32 cycles.
    CLR = 1'b1;
    step();
    quiet();
    chk("clr2_wdrop_cleared", {31'b0, WDROP}, 32'h0);
    n = 0;
    while (BUSY && n < 64) begin n++; step(); end
    chk("clr2_busy_cycles", 32'(n), 32'd32);

    // CLR colliding with a write, then reset part-way through the clear.
    wr(5'd9, 32'h99);
    wr(5'd31, 32'h1F);
    CLR = 1'b1; WE = 1'b1; WADDR = 5'd9; WDATA = 32'h1234;
    step();
    quiet();
    chk("clrwe_wdrop", {31'b0, WDROP}, 32'h1);
    chk("clrwe_busy", {31'b0, BUSY}, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      quiet();
      if (k == 3)  begin RE_A = 1'b1; RADDR_A = 5'd9; end
      if (k == 12) begin RE_A = 1'b1; RADDR_A = 5'd31; end
      step();
      if (k == 3) chk("clrwe_rd9_unchanged", RDATA_A, 32'h99);
    end
    quiet();
    chk("pre_rst_rvalid", {31'b0, RVALID_A}, 32'h1);
    chk("pre_rst_rdata", RDATA_A, 32'h1F);
    RST_N = 1'b0;
    #1;
    chk("async_rst_busy", {31'b0, BUSY}, 32'h0);
    chk("async_rst_rvalid", {31'b0, RVALID_A}, 32'h0);
    chk("async_rst_rdata", RDATA_A, 32'h0);
    chk("async_rst_wdrop", {31'b0, WDROP}, 32'h0);
    #2 RST_N = 1'b1;
    step();
    rd_a(5'd31, 32'h0, "after_rst_rd31");
    rd_a(5'd9, 32'h0, "after_rst_rd9");
    CLR = 1'b1;
    step();
    quiet();
    n = 0;
    while (BUSY && n < 64) begin n++; step(); end
    chk("after_rst_busy_cycles", 32'(n), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parametrised clocked register file, successor to the 32x32 tristate read-mux decoder block.
- One synchronous write port and two independent registered read ports.
- Write-first bypass on same-address collisions.
- Background clear engine that zeroes the array one entry per cycle.
- Sits between datapath and ALU operand fetch; replaces combinational tristate selection with a flop array and multiplexed reads.

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (32 by default).

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- WE  input  1  write enable, sampled on CLK rise.
- WADDR  input  ADDR_W  write address.
- WDATA  input  DATA_W  write data.
- RE_A  input  1  read request, port A.
- RADDR_A  input  ADDR_W  read address, port A.
- RDATA_A  output  DATA_W  registered read data, port A.
- RVALID_A  output  1  RDATA_A valid; pulses the cycle after RE_A.
- RE_B  input  1  read request, port B.
- RADDR_B  input  ADDR_W  read address, port B.
- RDATA_B  output  DATA_W  registered read data, port B.
- RVALID_B  output  1  RDATA_B valid; pulses the cycle after RE_B.
- CLR  input  1  start background clear (single-cycle pulse or level).
- BUSY  output  1  high while the clear engine runs.
- WDROP  output  1  sticky: a write was discarded during clear; cleared by reset or a new CLR start.

Behaviour:
- Reset (RST_N=0, async):
  - All DEPTH entries are set to 0.
  - RDATA_A/B=0, RVALID_A/B=0, BUSY=0, WDROP=0.
  - FSM goes to IDLE; clear pointer goes to 0.
  - Removing reset takes effect on the next CLK rise.
- Write: in IDLE, when WE=1 at a CLK rise, entry[WADDR] <= WDATA. Write latency is 1 cycle.
- Read latency is 1 cycle. When RE_x=1 at edge N:
  - RDATA_x <= entry[RADDR_x].
  - RVALID_x = 1 for exactly the following cycle.
  - When RE_x=0, RVALID_x <= 0 and RDATA_x holds its last value.
- Bypass, write-first: if WE=1, RE_x=1 and RADDR_x==WADDR at the same edge, and the write is accepted, then RDATA_x <= WDATA. Both ports may bypass simultaneously.
- Both read ports may address the same entry in the same cycle; each returns identical data.
- FSM states:
  - IDLE: CLR=1 -> CLEAR, pointer <= 0, BUSY <= 1, WDROP <= 0.
  - CLEAR: each cycle, entry[pointer] <= 0 and pointer increments.
    - When pointer == DEPTH-1, the last entry is cleared, then -> IDLE and BUSY <= 0.
    - Clear lasts exactly DEPTH cycles; BUSY is high for DEPTH cycles after the CLR edge.
  - CLR asserted while in CLEAR is ignored (no restart).
- Writes during CLEAR:
  - WE=1 is discarded and WDROP <= 1.
  - This applies even to addresses already cleared; the array does not change except by the scrub.
- Reads during CLEAR are honoured and return current contents.
  - If RADDR_x equals the entry being cleared that cycle, RDATA_x <= 0 (scrub bypass).
- CLR and WE at the same edge in IDLE: the write is dropped, WDROP <= 1, and the clear starts.
- Reset mid-CLEAR: takes effect immediately; BUSY=0, array is 0, FSM goes to IDLE.
- Pointer is ADDR_W bits wide; its wrap from DEPTH-1 to 0 coincides with the exit to IDLE.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- When defined:
  - Entry 0 is hardwired to zero; writes to WADDR=0 are silently discarded (WDROP is not set).
  - Reads of address 0 always return 0, including when a bypass to address 0 is attempted.
- When undefined: entry 0 is an ordinary register.

Test Plan:
- Reset, write 0xDEADBEEF to addr 5, next cycle RE_A=1 RADDR_A=5 -> following cycle RDATA_A=0xDEADBEEF, RVALID_A=1; one cycle later RVALID_A=0.
- WE=1 WADDR=7 WDATA=0x12345678 with RE_A=RE_B=1, RADDR_A=RADDR_B=7, same edge (old value 0x0) -> both RDATA=0x12345678 next cycle.
- Fill addrs 0..31 with value=addr, pulse CLR -> BUSY high 32 cycles. Read addr 31 at clear cycle 10 -> 0x1F. Read addr 31 after BUSY falls -> 0x0. WE during BUSY -> WDROP=1, target unchanged.
- Reads during CLEAR: read addr 3 in the cycle pointer=3 -> RDATA=0; read addr 3 in the cycle pointer=2 -> 0x3.
- Assert RST_N=0 at clear cycle 12 -> BUSY=0, RVALID=0 asynchronously; a subsequent CLR gives the full 32-cycle sequence.
- With REGFILE_ZERO_REG_EN: write 0xFFFFFFFF to addr 0, then read -> 0x0, WDROP=0. Without the macro -> 0xFFFFFFFF.
